// File: rtl/cu_command_credit_arbiter.sv
// -----------------------------------------------------------------------------
// cu_command_credit_arbiter
//
// Downstream stage of the CU control shell. Four command streams (read, write,
// prefetch_read, prefetch_write) are buffered in per-channel FIFOs. They are
// round-robin arbitrated onto one registered command port toward the AFU.
// Issue is gated by a command-credit counter that credit returns replenish.
// Per-channel buffer status is reported upstream as backpressure.
//
// Ports
//   clock                         single clock, all logic on posedge
//   rst_in                        asynchronous reset, active-high
//   enabled_in                    grant enable
//   read_command_in               channel 0 push (valid + payload)
//   write_command_in              channel 1 push
//   prefetch_read_command_in      channel 2 push
//   prefetch_write_command_in     channel 3 push
//   credit_return_in              one credit returned per asserted cycle
//   command_out                   arbitrated command, registered
//   read_buffer_status            channel 0 full/alfull/empty/valid (registered)
//   write_buffer_status           channel 1
//   prefetch_read_buffer_status   channel 2
//   prefetch_write_buffer_status  channel 3
//   credits_available             current credit count
//   overflow_error                sticky: a push was dropped on a full FIFO
//   perf_status                   {issued[31:0], credit_stall_cycles[31:0]}
//
// Handshake: the command inputs are valid-only pushes with no ready. The
// upstream producer must stop pushing once it sees alfull for that channel;
// the two spare entries absorb the producer's one-cycle output register.
// command_out.valid marks one issued command per asserted cycle; the AFU side
// has no ready, flow control on that side is entirely the credit counter.
//
// Optional feature: define CMD_ARB_PERF_COUNTERS_EN to build the issue and
// credit-stall counters into perf_status; otherwise perf_status is tied to 0.
// -----------------------------------------------------------------------------

package cu_command_credit_arbiter_pkg;
  localparam int PAYLOAD_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [PAYLOAD_W-1:0] payload;
  } CommandBufferLine;

  typedef struct packed {
    logic full;
    logic alfull;
    logic empty;
    logic valid;
  } BufferStatus;
endpackage

module cu_command_credit_arbiter
  import cu_command_credit_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int CREDITS_MAX = 32,
  parameter int CREDIT_W    = 6
) (
  input  logic                clock,
  input  logic                rst_in,
  input  logic                enabled_in,
  input  CommandBufferLine    read_command_in,
  input  CommandBufferLine    write_command_in,
  input  CommandBufferLine    prefetch_read_command_in,
  input  CommandBufferLine    prefetch_write_command_in,
  input  logic                credit_return_in,
  output CommandBufferLine    command_out,
  output BufferStatus         read_buffer_status,
  output BufferStatus         write_buffer_status,
  output BufferStatus         prefetch_read_buffer_status,
  output BufferStatus         prefetch_write_buffer_status,
  output logic [CREDIT_W-1:0] credits_available,
  output logic                overflow_error,
  output logic [63:0]         perf_status
);

  localparam int N_CH  = 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ALFULL = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [CREDIT_W:0]   CREDIT_SAT = (CREDIT_W + 1)'(CREDITS_MAX);
  localparam logic [CREDIT_W-1:0] CREDIT_RST = CREDIT_W'(CREDITS_MAX);

  CommandBufferLine     push_line [N_CH];
  logic [PAYLOAD_W-1:0] mem       [N_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr    [N_CH];
  logic [PTR_W-1:0]     rd_ptr    [N_CH];
  logic [CNT_W-1:0]     cnt       [N_CH];
  logic [CNT_W-1:0]     cnt_next  [N_CH];
  BufferStatus          status_q  [N_CH];

  logic [N_CH-1:0]      non_empty;
  logic [N_CH-1:0]      pop;
  logic [N_CH-1:0]      push_ok;
  logic                 overflow_hit;

  // rr_ptr is the first channel searched on the next cycle (one past the
  // last granted channel).
  logic [1:0]           rr_ptr;
  logic [1:0]           search_ch;
  logic [1:0]           grant_ch;
  logic                 grant;

  logic [CREDIT_W-1:0]  credits;
  logic [CREDIT_W-1:0]  credits_next;
  logic [CREDIT_W:0]    credit_sum;

  assign push_line[0] = read_command_in;
  assign push_line[1] = write_command_in;
  assign push_line[2] = prefetch_read_command_in;
  assign push_line[3] = prefetch_write_command_in;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      non_empty[i] = (cnt[i] != '0);
    end
  end

  // Round-robin search starting at rr_ptr, first non-empty channel wins.
  always_comb begin
    grant     = 1'b0;
    grant_ch  = rr_ptr;
    search_ch = rr_ptr;
    if (enabled_in && (credits != '0)) begin
      for (int k = 0; k < N_CH; k++) begin
        search_ch = rr_ptr + 2'(k);
        if (!grant && non_empty[search_ch]) begin
          grant    = 1'b1;
          grant_ch = search_ch;
        end
      end
    end
  end

  // Fullness is judged after this cycle's pop, so a full FIFO that is being
  // drained still accepts a push on the same edge.
  always_comb begin
    overflow_hit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      pop[i]      = grant && (grant_ch == 2'(i));
      push_ok[i]  = push_line[i].valid && ((cnt[i] != CNT_FULL) || pop[i]);
      cnt_next[i] = cnt[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
      if (push_line[i].valid && !push_ok[i]) begin
        overflow_hit = 1'b1;
      end
    end
  end

  // A grant is only possible with credits > 0, so the sum never goes negative.
  always_comb begin
    credit_sum = {1'b0, credits} - (CREDIT_W + 1)'(grant)
               + (CREDIT_W + 1)'(credit_return_in);
    if (credit_sum > CREDIT_SAT) begin
      credits_next = CREDIT_RST;
    end else begin
      credits_next = credit_sum[CREDIT_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        cnt[i]      <= '0;
        status_q[i] <= '{full: 1'b0, alfull: 1'b0, empty: 1'b1, valid: 1'b0};
      end
      rr_ptr         <= '0;
      credits        <= CREDIT_RST;
      overflow_error <= 1'b0;
      command_out    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (push_ok[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        cnt[i]             <= cnt_next[i];
        status_q[i].full   <= (cnt_next[i] == CNT_FULL);
        status_q[i].alfull <= (cnt_next[i] >= CNT_ALFULL);
        status_q[i].empty  <= (cnt_next[i] == '0);
        status_q[i].valid  <= (cnt_next[i] != '0);
      end
      if (grant) begin
        rr_ptr              <= grant_ch + 2'd1;
        command_out.valid   <= 1'b1;
        command_out.payload <= mem[grant_ch][rd_ptr[grant_ch]];
      end else begin
        // Payload holds its last value while idle.
        command_out.valid <= 1'b0;
      end
      credits <= credits_next;
      if (overflow_hit) begin
        overflow_error <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers and counts define what is valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_CH; i++) begin
      if (push_ok[i]) begin
        mem[i][wr_ptr[i]] <= push_line[i].payload;
      end
    end
  end

  assign read_buffer_status           = status_q[0];
  assign write_buffer_status          = status_q[1];
  assign prefetch_read_buffer_status  = status_q[2];
  assign prefetch_write_buffer_status = status_q[3];
  assign credits_available            = credits;

`ifdef CMD_ARB_PERF_COUNTERS_EN
  logic [31:0] issued_cnt;
  logic [31:0] stall_cnt;

  // Stall cycle: work is pending and granting is enabled, but no credit.
  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (grant) begin
        issued_cnt <= issued_cnt + 32'd1;
      end
      if (enabled_in && (|non_empty) && (credits == '0)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign perf_status = {issued_cnt, stall_cnt};
`else
  assign perf_status = '0;
`endif

endmodule
